// File: rtl/bitplane_encoder.sv
// Bit-plane encoder: splits a 16-byte word into two 8-byte groups, drops all-zero bit-planes
// and packs the survivors MSB-first. Optional ENCODER_STATS_EN adds handshake/saving counters.
module bitplane_encoder #(
    parameter int IO_DATA_WIDTH = 8,
    parameter int MEM_BW        = 128
) (
    input  logic              clk,
    input  logic              arst_n_in,
    input  logic [MEM_BW-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [15:0]       mask_out,
    output logic [MEM_BW-1:0] packed_out,
    output logic [4:0]        nz_planes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        dbg_state
`ifdef ENCODER_STATS_EN
    ,
    output logic [31:0]       words_cnt,
    output logic [31:0]       planes_saved_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and data/valid are held stable until the transfer.
    typedef enum logic [1:0] {S_IDLE, S_G0, S_G1, S_OUT} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [MEM_BW-1:0]   r_data;
    logic [MEM_BW-1:0]   r_packed;
    logic [15:0]         r_mask;
    logic [7:0]          r_ptr;
    logic [4:0]          r_cnt;

    logic [MEM_BW/2-1:0] w_grp;
    logic [MEM_BW/2-1:0] w_bits;
    logic [3:0]          w_n;
    logic [7:0]          w_gmask;
    logic [7:0]          w_shift;
    logic [MEM_BW-1:0]   w_place;
    logic                w_accept;

    assign in_ready   = arst_n_in & ((r_state == S_IDLE) | ((r_state == S_OUT) & out_ready));
    assign w_accept   = in_valid & in_ready;
    assign out_valid  = (r_state == S_OUT);
    assign mask_out   = r_mask;
    assign packed_out = r_packed;
    assign nz_planes  = r_cnt;
    assign dbg_state  = r_state;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_G0;
            S_G0:    w_next = S_G1;
            S_G1:    w_next = S_OUT;
            S_OUT:   if (out_ready) w_next = in_valid ? S_G0 : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Compact the current group's surviving planes; plane bit k lands at field bit 7-k.
    always_comb begin
        logic [7:0] field;
        w_grp   = (r_state == S_G1) ? r_data[MEM_BW/2-1:0] : r_data[MEM_BW-1:MEM_BW/2];
        w_bits  = '0;
        w_n     = '0;
        w_gmask = '0;
        for (int i = 7; i >= 0; i--) begin
            field = '0;
            for (int k = 0; k < 8; k++) field[7-k] = w_grp[(7-k)*IO_DATA_WIDTH + i];
            if (field != 8'd0) begin
                w_gmask[i] = 1'b1;
                w_bits     = w_bits | ({field, 56'd0} >> {w_n, 3'b000});
                w_n        = w_n + 4'd1;
            end
        end
    end

    // The pointer only matters as an offset: 127 - ptr is the number of bits already written.
    assign w_shift = 8'd127 - r_ptr;
    assign w_place = {w_bits, {(MEM_BW/2){1'b0}}} >> w_shift;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_data   <= '0;
            r_packed <= '0;
            r_mask   <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_data   <= in_data;
            r_packed <= '0;
            r_mask   <= '0;
            r_ptr    <= 8'd127;
            r_cnt    <= '0;
        end else if (r_state == S_G0 || r_state == S_G1) begin
            if (r_state == S_G0) r_mask[15:8] <= w_gmask;
            else                 r_mask[7:0]  <= w_gmask;
            r_packed <= r_packed | w_place;
            r_ptr    <= r_ptr - {1'b0, w_n, 3'b000};
            r_cnt    <= r_cnt + {1'b0, w_n};
        end
    end

`ifdef ENCODER_STATS_EN
    logic        w_hs;
    logic [32:0] w_saved_sum;

    assign w_hs        = out_valid & out_ready;
    assign w_saved_sum = {1'b0, planes_saved_cnt} + (33'd16 - {28'd0, r_cnt});

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            words_cnt        <= '0;
            planes_saved_cnt <= '0;
        end else if (w_hs) begin
            if (words_cnt != 32'hFFFF_FFFF) words_cnt <= words_cnt + 32'd1;
            planes_saved_cnt <= w_saved_sum[32] ? 32'hFFFF_FFFF : w_saved_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_bitplane_encoder.sv
// Self-checking bench for bitplane_encoder: directed vector table, backpressure and reset
// sequences, then randomized traffic checked against a plane-list model and a decoder model.
module tb_bitplane_encoder;

    logic         clk;
    logic         arst_n_in;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  mask_out;
    logic [127:0] packed_out;
    logic [4:0]   nz_planes;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   dbg_state;
`ifdef ENCODER_STATS_EN
    logic [31:0]  words_cnt;
    logic [31:0]  planes_saved_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam int W = 149;
    logic [W-1:0]   exp_q[$];
    logic [127:0]   data_q[$];

    bitplane_encoder #(.IO_DATA_WIDTH(8), .MEM_BW(128)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mask_out(mask_out), .packed_out(packed_out),
        .nz_planes(nz_planes), .out_valid(out_valid), .out_ready(out_ready),
        .dbg_state(dbg_state)
`ifdef ENCODER_STATS_EN
        , .words_cnt(words_cnt), .planes_saved_cnt(planes_saved_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: list surviving planes in emit order, then lay them out 8 bits at a time
    function automatic logic [W-1:0] model(input logic [127:0] d);
        logic [15:0]  m = '0;
        logic [127:0] p = '0;
        logic [7:0]   q[$];
        for (int j = 0; j < 2; j++)
            for (int i = 7; i >= 0; i--) begin
                logic [7:0] pl;
                for (int k = 0; k < 8; k++) pl[k] = d[(15 - (8*j + k))*8 + i];
                if (pl != 0) begin
                    m[i + 8*(1-j)] = 1'b1;
                    q.push_back(pl);
                end
            end
        for (int n = 0; n < q.size(); n++)
            for (int k = 0; k < 8; k++) p[127 - 8*n - k] = q[n][k];
        return {m, p, 5'(q.size())};
    endfunction

    function automatic logic [127:0] decode(input logic [15:0] m, input logic [127:0] p);
        logic [127:0] d = '0;
        int pos = 127;
        for (int b = 15; b >= 0; b--)
            if (m[b]) begin
                int j = (b >= 8) ? 0 : 1;
                int i = b % 8;
                for (int k = 0; k < 8; k++) d[(15 - (8*j + k))*8 + i] = p[pos - k];
                pos -= 8;
            end
        return d;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard compare of the current outputs against an expected record and source word
    task automatic check_out(input string pfx, input logic [W-1:0] e, input logic [127:0] src);
        check({pfx, "_mask"},   128'(mask_out),   128'(e[148:133]));
        check({pfx, "_packed"}, packed_out,       e[132:5]);
        check({pfx, "_nz"},     128'(nz_planes),  128'(e[4:0]));
        check({pfx, "_popcnt"}, 128'(nz_planes),  128'($countones(mask_out)));
        check({pfx, "_decode"}, decode(mask_out, packed_out), src);
    endtask

    // driver: called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic accept_word(input logic [127:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic latency_checks(input string pfx);
        @(negedge clk); check({pfx, "_lat_e0"}, 128'(out_valid), 128'd0);
        @(negedge clk); check({pfx, "_lat_e1"}, 128'(out_valid), 128'd0);
        @(negedge clk); check({pfx, "_lat_e2"}, 128'(out_valid), 128'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    typedef struct {
        logic [127:0] din;
        logic [15:0]  mask;
        logic [127:0] pk;
        logic [4:0]   nz;
    } vec_t;

    initial begin
        vec_t         vt[7];
        logic [127:0] a, b;
        int           sent, recv, cyc;

        vt[0] = '{128'd0, 16'h0000, 128'd0, 5'd0};
        vt[1] = '{{128{1'b1}}, 16'hFFFF, {128{1'b1}}, 5'd16};
        vt[2] = '{128'h80 << 120, 16'h8000, 128'd1 << 127, 5'd1};
        vt[3] = '{128'h01, 16'h0001, 128'h01 << 120, 5'd1};
        vt[4] = '{128'h01 << 56, 16'h0001, 128'd1 << 127, 5'd1};
        vt[5] = '{128'hFF << 64, 16'hFF00, 128'h0101_0101_0101_0101 << 64, 5'd8};
        vt[6] = '{(128'h01 << 120) | 128'h80, 16'h0180, 128'h8001 << 112, 5'd2};

        arst_n_in = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready",  128'(in_ready),  128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_mask",      128'(mask_out),  128'd0);
        check("rst_packed",    packed_out,      128'd0);
        check("rst_nz",        128'(nz_planes), 128'd0);
        repeat (2) @(negedge clk);
        arst_n_in = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;

        // directed vector table
        foreach (vt[v]) begin
            accept_word(vt[v].din);
            latency_checks($sformatf("vec%0d", v));
            check_out($sformatf("vec%0d", v), {vt[v].mask, vt[v].pk, vt[v].nz}, vt[v].din);
            release_out();
        end

        // backpressure with a waiting word, then same-cycle handshake and accept
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom} & {16{8'h5A}};
        accept_word(a);
        latency_checks("bp_a");
        in_valid = 1'b1;
        in_data  = b;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_in_ready_low", 128'(in_ready),  128'd0);
            check("bp_valid_held",   128'(out_valid), 128'd1);
            check_out("bp_hold", model(a), a);
        end
        out_ready = 1'b1;
        #1 check("bp_same_cycle_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        latency_checks("bp_b");
        check_out("bp_b", model(b), b);
        release_out();

        // reset asserted while encoding group 1
        accept_word({16{8'hC3}});
        @(posedge clk);
        #2 arst_n_in = 1'b0;
        #1;
        check("g1rst_out_valid", 128'(out_valid), 128'd0);
        check("g1rst_mask",      128'(mask_out),  128'd0);
        check("g1rst_packed",    packed_out,      128'd0);
        check("g1rst_nz",        128'(nz_planes), 128'd0);
        check("g1rst_in_ready",  128'(in_ready),  128'd0);
        @(posedge clk);
        #1 arst_n_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("g1rst_in_ready_after", 128'(in_ready),  128'd1);
            check("g1rst_no_emit",        128'(out_valid), 128'd0);
        end
        @(posedge clk);
        #1;

        // randomized traffic against the scoreboard
        sent = 0;
        recv = 0;
        cyc  = 0;
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        out_ready = $urandom_range(0, 1);
        while (recv < 1000 && cyc < 30000) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_output", 128'(out_valid), 128'd0);
                end else begin
                    check_out("rand", exp_q.pop_front(), data_q.pop_front());
                    recv++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data));
                data_q.push_back(in_data);
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
            in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       in_data = '0;
                1:       in_data = {$urandom, $urandom, $urandom, $urandom} & {16{8'h81}};
                default: in_data = {$urandom, $urandom, $urandom, $urandom};
            endcase
            out_ready = $urandom_range(0, 1);
        end
        check("rand_words_received", 128'(recv), 128'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
